// File: rtl/user_rd_arbiter.sv
// Round-robin arbiter that shares one credit-limited read request channel among
// N_REQ requesters and steers returned read beats back to the owner of the head request.
module user_rd_arbiter #(
  parameter int unsigned N_REQ         = 4,
  parameter int unsigned DATA_BITS     = 512,
  parameter int unsigned LEN_BITS      = 28,
  parameter int unsigned VADDR_BITS    = 48,
  parameter int unsigned N_OUTSTANDING = 8,
  localparam int unsigned ID_BITS      = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                        aclk,
  input  logic                        aresetn,
  input  logic [N_REQ-1:0]            s_req_valid,
  output logic [N_REQ-1:0]            s_req_ready,
  input  logic [N_REQ*VADDR_BITS-1:0] s_req_vaddr,
  input  logic [N_REQ*LEN_BITS-1:0]   s_req_len,
  output logic                        m_req_valid,
  input  logic                        m_req_ready,
  output logic [VADDR_BITS-1:0]       m_req_vaddr,
  output logic [LEN_BITS-1:0]         m_req_len,
  output logic [ID_BITS-1:0]          m_req_id,
  input  logic                        rxfer,
  output logic                        rd_sel_valid,
  output logic [ID_BITS-1:0]          rd_sel,
  output logic                        rd_last,
  output logic                        err_underflow
);

  localparam int unsigned BEAT_LOG  = $clog2(DATA_BITS / 8);
  localparam int unsigned CNT_BITS  = LEN_BITS - BEAT_LOG;
  localparam int unsigned CRED_BITS = $clog2(N_OUTSTANDING + 1);
  localparam int unsigned QA_BITS   = (N_OUTSTANDING > 1) ? $clog2(N_OUTSTANDING) : 1;

  typedef enum logic {ST_IDLE, ST_READ} state_t;

  logic [VADDR_BITS-1:0] req_vaddr [N_REQ];
  logic [LEN_BITS-1:0]   req_len   [N_REQ];

  for (genvar g = 0; g < N_REQ; g++) begin : g_unpack
    assign req_vaddr[g] = s_req_vaddr[g*VADDR_BITS +: VADDR_BITS];
    assign req_len[g]   = s_req_len[g*LEN_BITS +: LEN_BITS];
  end

  logic [ID_BITS-1:0]   ptr_q;
  logic [ID_BITS-1:0]   win_id;
  logic                 win_found;
  logic [LEN_BITS-1:0]  win_len;
  logic [LEN_BITS-1:0]  win_len_m1;
  logic [CNT_BITS-1:0]  win_beats_m1;
  logic [CRED_BITS-1:0] cred_q;
  logic [CRED_BITS-1:0] q_count;
  logic [QA_BITS-1:0]   q_wr;
  logic [QA_BITS-1:0]   q_rd;
  logic [ID_BITS-1:0]   q_id  [N_OUTSTANDING];
  logic [CNT_BITS-1:0]  q_bm1 [N_OUTSTANDING];
  logic                 q_empty;
  logic                 q_full;
  logic                 out_free;
  logic                 cred_ok;
  logic                 accept;
  logic                 push;
  logic                 pop;
  logic                 retire;
  logic                 uflow;
  state_t               state_q, state_d;
  logic [CNT_BITS-1:0]  cnt_q, cnt_d;
  logic [ID_BITS-1:0]   sel_d;

  // First valid requester at or after the priority pointer, wrapping.
  always_comb begin
    int unsigned idx;
    idx       = 0;
    win_found = 1'b0;
    win_id    = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      idx = 32'(ptr_q) + k;
      if (idx >= N_REQ) idx = idx - N_REQ;
      if (!win_found && s_req_valid[ID_BITS'(idx)]) begin
        win_found = 1'b1;
        win_id    = ID_BITS'(idx);
      end
    end
  end

  assign win_len      = req_len[win_id];
  assign win_len_m1   = win_len - LEN_BITS'(1);
  assign win_beats_m1 = CNT_BITS'(win_len_m1 >> BEAT_LOG);

  assign q_empty  = (q_count == '0);
  assign q_full   = (q_count == CRED_BITS'(N_OUTSTANDING));
  assign out_free = !m_req_valid || m_req_ready;
  assign cred_ok  = (cred_q < CRED_BITS'(N_OUTSTANDING)) || retire;
  assign accept   = aresetn && win_found && out_free && !q_full && cred_ok;
  assign push     = accept && (win_len != '0);

  always_comb begin
    s_req_ready = '0;
    if (accept) s_req_ready[win_id] = 1'b1;
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      ptr_q <= '0;
    end else if (accept) begin
      ptr_q <= (win_id == ID_BITS'(N_REQ - 1)) ? '0 : win_id + ID_BITS'(1);
    end
  end

  // Output stage: a zero-length accept only lets a draining request leave.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      m_req_valid <= 1'b0;
    end else if (push) begin
      m_req_valid <= 1'b1;
    end else if (m_req_ready) begin
      m_req_valid <= 1'b0;
    end
  end

  always_ff @(posedge aclk) begin
    if (push) begin
      m_req_vaddr <= req_vaddr[win_id];
      m_req_len   <= win_len;
      m_req_id    <= win_id;
    end
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      cred_q <= '0;
    end else if (push && !retire) begin
      cred_q <= cred_q + CRED_BITS'(1);
    end else if (retire && !push) begin
      cred_q <= cred_q - CRED_BITS'(1);
    end
  end

  // In-order queue of {id, beats_m1} for issued requests.
  function automatic logic [QA_BITS-1:0] q_next(input logic [QA_BITS-1:0] p);
    return (p == QA_BITS'(N_OUTSTANDING - 1)) ? '0 : p + QA_BITS'(1);
  endfunction

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      q_wr    <= '0;
      q_rd    <= '0;
      q_count <= '0;
    end else begin
      if (push) q_wr <= q_next(q_wr);
      if (pop)  q_rd <= q_next(q_rd);
      if (push && !pop)      q_count <= q_count + CRED_BITS'(1);
      else if (pop && !push) q_count <= q_count - CRED_BITS'(1);
    end
  end

  always_ff @(posedge aclk) begin
    if (push) begin
      q_id[q_wr]  <= win_id;
      q_bm1[q_wr] <= win_beats_m1;
    end
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      rd_sel        <= '0;
      rd_sel_valid  <= 1'b0;
      rd_last       <= 1'b0;
      err_underflow <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      rd_sel        <= sel_d;
      rd_sel_valid  <= (state_d == ST_READ);
      rd_last       <= (state_d == ST_READ) && (cnt_d == '0);
      err_underflow <= err_underflow || uflow;
    end
  end

  // Head tracking: retiring the last beat reloads from the queue without a bubble.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sel_d   = rd_sel;
    pop     = 1'b0;
    retire  = 1'b0;
    uflow   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        uflow = rxfer;
        if (!q_empty) begin
          pop     = 1'b1;
          cnt_d   = q_bm1[q_rd];
          sel_d   = q_id[q_rd];
          state_d = ST_READ;
        end
      end
      ST_READ: begin
        if (rxfer) begin
          if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_BITS'(1);
          end else begin
            retire = 1'b1;
            if (!q_empty) begin
              pop   = 1'b1;
              cnt_d = q_bm1[q_rd];
              sel_d = q_id[q_rd];
            end else begin
              state_d = ST_IDLE;
            end
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_user_rd_arbiter.sv
// Bench for user_rd_arbiter: directed vector table, corner sequences and random
// traffic checked every cycle against a queue-based reference model.
module tb_user_rd_arbiter;

  localparam int N  = 4;
  localparam int VB = 48;
  localparam int LB = 28;
  localparam int NO = 8;
  localparam int BL = 6;

  logic            aclk = 1'b0;
  logic            aresetn = 1'b0;
  logic [N-1:0]    s_req_valid = '0;
  logic [N-1:0]    s_req_ready;
  logic [N*VB-1:0] s_req_vaddr = '0;
  logic [N*LB-1:0] s_req_len = '0;
  logic            m_req_valid;
  logic            m_req_ready = 1'b0;
  logic [VB-1:0]   m_req_vaddr;
  logic [LB-1:0]   m_req_len;
  logic [1:0]      m_req_id;
  logic            rxfer = 1'b0;
  logic            rd_sel_valid;
  logic [1:0]      rd_sel;
  logic            rd_last;
  logic            err_underflow;

  user_rd_arbiter dut (
    .aclk(aclk), .aresetn(aresetn),
    .s_req_valid(s_req_valid), .s_req_ready(s_req_ready),
    .s_req_vaddr(s_req_vaddr), .s_req_len(s_req_len),
    .m_req_valid(m_req_valid), .m_req_ready(m_req_ready),
    .m_req_vaddr(m_req_vaddr), .m_req_len(m_req_len), .m_req_id(m_req_id),
    .rxfer(rxfer), .rd_sel_valid(rd_sel_valid), .rd_sel(rd_sel),
    .rd_last(rd_last), .err_underflow(err_underflow)
  );

  always #5 aclk = ~aclk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: priority pointer, credit count, FIFO of pending reads, head, output reg.
  int            m_ptr, m_cred;
  int            q_id[$];
  int            q_bm[$];
  bit            h_v;
  int            h_id, h_rem;
  bit            o_v;
  logic [VB-1:0] o_va;
  logic [LB-1:0] o_len;
  int            o_id;
  bit            m_err;
  bit            chk_en = 1'b0;

  logic [N-1:0]  snap_ready;
  bit            snap_sv, snap_last;
  int            snap_sel;
  int            acc_w;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [N-1:0] oh(input int i);
    logic [N-1:0] r;
    r = '0;
    r[i] = 1'b1;
    return r;
  endfunction

  function automatic int beats_m1(input logic [LB-1:0] len);
    logic [LB-1:0] t;
    t = len - LB'(1);
    return int'(t >> BL);
  endfunction

  function automatic logic [VB-1:0] rva();
    return VB'({$urandom(), $urandom()});
  endfunction

  task automatic model_reset();
    m_ptr = 0; m_cred = 0; q_id.delete(); q_bm.delete();
    h_v = 0; h_id = 0; h_rem = 0; o_v = 0; m_err = 0;
  endtask

  task automatic set_req(input int i, input bit v, input logic [VB-1:0] va, input logic [LB-1:0] ln);
    s_req_valid[i] = v;
    s_req_vaddr[i*VB +: VB] = va;
    s_req_len[i*LB +: LB] = ln;
  endtask

  // One clock: compare outputs against the model, then advance the model at the edge.
  task automatic cycle();
    int w, idx;
    bit ret, acc;
    logic [N-1:0] er;
    logic [VB-1:0] va;
    logic [LB-1:0] ln;
    #1;
    w = -1;
    for (int k = 0; k < N; k++) begin
      idx = (m_ptr + k) % N;
      if (w < 0 && s_req_valid[idx]) w = idx;
    end
    ret = h_v && rxfer && (h_rem == 0);
    acc = aresetn && (w >= 0) && (!o_v || m_req_ready) && (q_id.size() < NO) && (m_cred < NO || ret);
    er = '0; va = '0; ln = '0;
    if (acc) begin
      er[w] = 1'b1;
      va = s_req_vaddr[w*VB +: VB];
      ln = s_req_len[w*LB +: LB];
    end
    snap_ready = s_req_ready; snap_sv = rd_sel_valid; snap_last = rd_last; snap_sel = int'(rd_sel);
    acc_w = acc ? w : -1;
    if (chk_en) begin
      check("s_req_ready", 64'(s_req_ready), 64'(er));
      check("m_req_valid", 64'(m_req_valid), 64'(o_v));
      if (o_v) begin
        check("m_req_vaddr", 64'(m_req_vaddr), 64'(o_va));
        check("m_req_len", 64'(m_req_len), 64'(o_len));
        check("m_req_id", 64'(m_req_id), 64'(o_id));
      end
      check("rd_sel_valid", 64'(rd_sel_valid), 64'(h_v));
      check("rd_last", 64'(rd_last), 64'(h_v && h_rem == 0));
      if (h_v) check("rd_sel", 64'(rd_sel), 64'(h_id));
      check("err_underflow", 64'(err_underflow), 64'(m_err));
    end
    @(posedge aclk);
    if (!aresetn) begin
      model_reset();
    end else begin
      if (!h_v) begin
        if (rxfer) m_err = 1;
        if (q_id.size() > 0) begin h_v = 1; h_id = q_id.pop_front(); h_rem = q_bm.pop_front(); end
      end else if (rxfer) begin
        if (h_rem > 0) h_rem--;
        else begin
          m_cred--;
          if (q_id.size() > 0) begin h_id = q_id.pop_front(); h_rem = q_bm.pop_front(); end
          else h_v = 0;
        end
      end
      if (acc && ln != 0) begin
        q_id.push_back(w); q_bm.push_back(beats_m1(ln)); m_cred++;
        o_v = 1; o_va = va; o_len = ln; o_id = w;
      end else if (m_req_ready) begin
        o_v = 0;
      end
      if (acc) m_ptr = (w + 1) % N;
    end
    #1;
  endtask

  task automatic drain();
    int t;
    s_req_valid = '0; m_req_ready = 1'b1;
    for (t = 0; t < 600; t++) begin
      if (!h_v && q_id.size() == 0 && !o_v) break;
      rxfer = h_v;
      cycle();
    end
    rxfer = 1'b0;
    check("drain_done", 64'(t < 600), 64'(1));
  endtask

  typedef struct {
    int            rq;
    logic [LB-1:0] len;
    int            beats;
  } vec_t;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vec_t          tbl[7];
    int            ord[8];
    int            il[6];
    int            gcnt[N];
    int            n, t, beats;
    bit            got_last;
    logic [VB-1:0] va;

    tbl[0] = '{0, 28'd256, 4};
    tbl[1] = '{1, 28'd1, 1};
    tbl[2] = '{2, 28'd65, 2};
    tbl[3] = '{3, 28'd64, 1};
    tbl[4] = '{1, 28'd0, 0};
    tbl[5] = '{2, 28'd128, 2};
    tbl[6] = '{3, 28'd4096, 64};
    ord = '{0, 1, 2, 3, 0, 1, 2, 3};
    il  = '{2, 2, 0, 0, 3, 3};

    // Reset state
    model_reset();
    cycle();
    chk_en = 1'b1;
    cycle();
    aresetn = 1'b1;
    check("rst_m_valid", 64'(m_req_valid), 64'(0));
    check("rst_sel_valid", 64'(rd_sel_valid), 64'(0));
    check("rst_err", 64'(err_underflow), 64'(0));

    // Single-request vectors: grant, issue next cycle, beat count and last beat
    m_req_ready = 1'b1;
    for (int v = 0; v < 7; v++) begin
      va = rva();
      set_req(tbl[v].rq, 1'b1, va, tbl[v].len);
      cycle();
      check("tbl_grant", 64'(snap_ready), 64'(oh(tbl[v].rq)));
      set_req(tbl[v].rq, 1'b0, va, tbl[v].len);
      if (tbl[v].beats == 0) begin
        repeat (3) cycle();
        check("tbl_zero_no_mreq", 64'(m_req_valid), 64'(0));
        check("tbl_zero_no_head", 64'(rd_sel_valid), 64'(0));
      end else begin
        check("tbl_mreq_valid", 64'(m_req_valid), 64'(1));
        check("tbl_mreq_id", 64'(m_req_id), 64'(tbl[v].rq));
        check("tbl_mreq_vaddr", 64'(m_req_vaddr), 64'(va));
        beats = 0; got_last = 1'b0;
        for (t = 0; t < 200; t++) begin
          rxfer = rd_sel_valid;
          cycle();
          if (snap_sv && rxfer) begin
            beats++;
            check("tbl_rd_sel", 64'(snap_sel), 64'(tbl[v].rq));
            if (snap_last) begin got_last = 1'b1; break; end
          end
        end
        rxfer = 1'b0;
        check("tbl_beats", 64'(beats), 64'(tbl[v].beats));
        check("tbl_last_seen", 64'(got_last), 64'(1));
        cycle();
        check("tbl_head_idle", 64'(rd_sel_valid), 64'(0));
      end
    end

    // Fairness: all requesters valid, grants rotate 0,1,2,3,...
    for (int i = 0; i < N; i++) begin set_req(i, 1'b1, rva(), 28'd64); gcnt[i] = 0; end
    n = 0;
    for (t = 0; t < 40 && n < 8; t++) begin
      rxfer = rd_sel_valid;
      cycle();
      if (snap_ready != '0) begin
        check("fair_grant", 64'(snap_ready), 64'(oh(ord[n])));
        for (int i = 0; i < N; i++) if (snap_ready[i]) gcnt[i]++;
        n++;
      end
    end
    check("fair_count", 64'(n), 64'(8));
    for (int i = 0; i < N; i++) check("fair_share", 64'(gcnt[i]), 64'(2));
    drain();

    // Credit limit: exactly NO accepts, then a last-beat retire admits one more
    for (int i = 0; i < N; i++) set_req(i, 1'b1, rva(), 28'd64);
    m_req_ready = 1'b1; rxfer = 1'b0; n = 0;
    for (t = 0; t < 14; t++) begin
      cycle();
      if (snap_ready != '0) n++;
    end
    check("cred_accepts", 64'(n), 64'(NO));
    #1;
    check("cred_blocked", 64'(s_req_ready), 64'(0));
    rxfer = 1'b1;
    cycle();
    check("cred_retire_accept", 64'(snap_ready != '0), 64'(1));
    rxfer = 1'b0;
    cycle();
    check("cred_still_full", 64'(snap_ready), 64'(0));
    drain();

    // Back-pressure: output register holds, no further accepts
    va = rva();
    m_req_ready = 1'b0;
    set_req(2, 1'b1, va, 28'd300);
    cycle();
    check("bp_grant", 64'(snap_ready), 64'(oh(2)));
    set_req(2, 1'b0, va, 28'd300);
    set_req(0, 1'b1, rva(), 28'd100);
    for (int k = 0; k < 10; k++) begin
      cycle();
      check("bp_no_accept", 64'(snap_ready), 64'(0));
      check("bp_vaddr_stable", 64'(m_req_vaddr), 64'(va));
      check("bp_len_stable", 64'(m_req_len), 64'(300));
    end
    m_req_ready = 1'b1;
    cycle();
    check("bp_release_accept", 64'(snap_ready), 64'(oh(0)));
    drain();

    // Interleaved returns for ids 2,0,3 with no bubble between heads
    m_req_ready = 1'b1; rxfer = 1'b0;
    foreach (ord[k]) if (k < 3) begin
      n = (k == 0) ? 2 : (k == 1) ? 0 : 3;
      set_req(n, 1'b1, rva(), 28'd128);
      cycle();
      check("il_grant", 64'(snap_ready), 64'(oh(n)));
      set_req(n, 1'b0, '0, '0);
    end
    for (t = 0; t < 10 && !rd_sel_valid; t++) cycle();
    check("il_head_ready", 64'(rd_sel_valid), 64'(1));
    rxfer = 1'b1;
    for (int k = 0; k < 6; k++) begin
      cycle();
      check("il_valid", 64'(snap_sv), 64'(1));
      check("il_sel", 64'(snap_sel), 64'(il[k]));
    end
    rxfer = 1'b0;
    cycle();
    check("il_idle", 64'(rd_sel_valid), 64'(0));

    // Underflow in idle is sticky
    rxfer = 1'b1;
    cycle();
    rxfer = 1'b0;
    repeat (3) cycle();
    check("uflow_sticky", 64'(err_underflow), 64'(1));

    // Reset with 3 requests outstanding
    for (int i = 0; i < 3; i++) begin
      set_req(i, 1'b1, rva(), 28'd256);
      cycle();
      set_req(i, 1'b0, '0, '0);
    end
    rxfer = 1'b1;
    cycle();
    rxfer = 1'b0;
    aresetn = 1'b0;
    cycle();
    aresetn = 1'b1;
    check("mid_rst_sel_valid", 64'(rd_sel_valid), 64'(0));
    check("mid_rst_err", 64'(err_underflow), 64'(0));
    check("mid_rst_m_valid", 64'(m_req_valid), 64'(0));
    rxfer = 1'b1;
    cycle();
    rxfer = 1'b0;
    cycle();
    check("post_rst_uflow", 64'(err_underflow), 64'(1));
    aresetn = 1'b0;
    cycle();
    aresetn = 1'b1;

    // Random traffic against the model
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!s_req_valid[i] && $urandom_range(0, 3) == 0) begin
          n = int'($urandom_range(0, 9));
          set_req(i, 1'b1, rva(),
                  (n == 0) ? 28'd0 : (n < 3) ? LB'($urandom_range(1, 64)) : LB'($urandom_range(65, 1024)));
        end
      end
      m_req_ready = ($urandom_range(0, 3) != 0);
      rxfer = h_v && ($urandom_range(0, 9) < 6);
      cycle();
      if (acc_w >= 0) s_req_valid[acc_w] = 1'b0;
    end
    drain();
    cycle();
    check("final_idle", 64'(rd_sel_valid), 64'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
